// File: rtl/pc_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_if
// Avalon-style instruction fetch bus between the fetch unit and the
// instruction memory.
//   instr_address     master -> slave  fetch address
//   instr_read        master -> slave  fetch request
//   instr_waitrequest slave  -> master 1 = memory not ready, hold the request
//   instr_readdata    slave  -> master fetched word
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] instr_address;
  logic              instr_read;
  logic              instr_waitrequest;
  logic [31:0]       instr_readdata;

  modport master (
    output instr_address,
    output instr_read,
    input  instr_waitrequest,
    input  instr_readdata
  );

  modport slave (
    input  instr_address,
    input  instr_read,
    output instr_waitrequest,
    output instr_readdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Owns the program counter, fetches instructions over an Avalon-style port
// with wait states, latches one instruction per EXEC cycle and executes MIPS
// branch delay slots (the instruction after a redirect always runs before
// the redirect target).
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : a redirect target with target[1:0] != 0 lets the delay slot
//               run, then enters FAULT (fault_o=1, active_o=0, no fetch).
//   undefined : target[1:0] is forced to 2'b00 and fault_o is tied 0.
//
// Ports
//   clk, reset      clock; synchronous active-high reset (beats clk_enable)
//   clk_enable_i    0 -> every register holds
//   ibus            fetch bus (master modport of pc_fetch_unit_if)
//   instr_out_o     latched instruction (IR)
//   instr_valid_o   IR valid for execution this cycle
//   stall_i         datapath not ready, hold EXEC
//   br_taken_i      conditional branch taken, target pc+4+sext(imm)<<2
//   jump_i          J/JAL, target {pc4[top], instr[25:0], 2'b00}
//   jr_i            JR/JALR, target jr_target_i
//   jr_target_i     register target
//   link_addr_o     pc+8 of the instruction in EXEC
//   active_o        0 once halted or faulted
//   fault_o         misaligned redirect seen
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(32'hBFC00000),
  parameter logic [ADDR_W-1:0]  HALT_ADDR    = ADDR_W'(32'h00000000)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable_i,
  pc_fetch_unit_if.master     ibus,
  output logic [31:0]         instr_out_o,
  output logic                instr_valid_o,
  input  logic                stall_i,
  input  logic                br_taken_i,
  input  logic                jump_i,
  input  logic                jr_i,
  input  logic [ADDR_W-1:0]   jr_target_i,
  output logic [ADDR_W-1:0]   link_addr_o,
  output logic                active_o,
  output logic                fault_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              read_q, valid_q, active_q, fault_q;

  logic [ADDR_W-1:0] pc4_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              misaligned_s;

  // Branch target: pc+4 plus the sign-extended word offset; wraps naturally.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0] pc4,
    input logic [31:0]       instr
  );
    logic [17:0] off;
    off = {instr[15:0], 2'b00};
    return pc4 + {{(ADDR_W-18){off[17]}}, off};
  endfunction

  // Jump target: keep pc+4 bits above 27, replace the low 28 bits.
  function automatic logic [ADDR_W-1:0] jump_target(
    input logic [ADDR_W-1:0] pc4,
    input logic [31:0]       instr
  );
    logic [ADDR_W-1:0] high_mask;
    high_mask = ~ADDR_W'(28'hFFFFFFF);
    return (pc4 & high_mask) | ADDR_W'({instr[25:0], 2'b00});
  endfunction

  // Without the alignment checker the low two target bits are discarded.
  function automatic logic [ADDR_W-1:0] fix_align(input logic [ADDR_W-1:0] t);
`ifdef ALIGN_CHECK_EN
    return t;
`else
    return {t[ADDR_W-1:2], 2'b00};
`endif
  endfunction

  assign pc4_s = pc_q + ADDR_W'(32'd4);

`ifdef ALIGN_CHECK_EN
  assign misaligned_s = (tgt_q[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // Next-state, PC, IR and delay-slot bookkeeping.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    next_pc_s = pc4_s;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!ibus.instr_waitrequest) begin
          ir_d    = ibus.instr_readdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (stall_i) begin
          state_d = S_EXEC;
        end else begin
          if (pend_q) begin
            // Current instruction is a delay slot: go to the stored target and
            // ignore any redirect it might request.
            next_pc_s = tgt_q;
            pend_d    = 1'b0;
          end else if (jr_i) begin
            pend_d = 1'b1;
            tgt_d  = fix_align(jr_target_i);
          end else if (jump_i) begin
            pend_d = 1'b1;
            tgt_d  = fix_align(jump_target(pc4_s, ir_q));
          end else if (br_taken_i) begin
            pend_d = 1'b1;
            tgt_d  = fix_align(branch_target(pc4_s, ir_q));
          end else begin
            pend_d = 1'b0;
          end
          if (pend_q && misaligned_s) begin
            state_d = S_FAULT;
          end else begin
            pc_d = next_pc_s;
            if (next_pc_s == HALT_ADDR) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      ir_q     <= 32'h00000000;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
      read_q   <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else if (clk_enable_i) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      read_q   <= (state_d == S_FETCH);
      valid_q  <= (state_d == S_EXEC);
      active_q <= (state_d != S_HALT) && (state_d != S_FAULT);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign ibus.instr_address = pc_q;
  assign ibus.instr_read    = read_q;
  assign instr_out_o        = ir_q;
  assign instr_valid_o      = valid_q;
  assign link_addr_o        = pc_q + ADDR_W'(32'd8);
  assign active_o           = active_q;
`ifdef ALIGN_CHECK_EN
  assign fault_o            = fault_q;
`else
  assign fault_o            = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Table of instruction records applied in a loop; expected fetch addresses
// and fetched words are queued and popped as the DUT fetches and executes.
// Hand-written sequences cover halt, clk_enable hold, reset mid-fetch and
// the misaligned redirect.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        stall, br_taken, jump, jr;
  logic [31:0] jr_target;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] link_addr;
  logic        active, fault;

  pc_fetch_unit_if #(.ADDR_W(32)) ibus ();

  pc_fetch_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable_i (clk_enable),
    .ibus         (ibus.master),
    .instr_out_o  (instr_out),
    .instr_valid_o(instr_valid),
    .stall_i      (stall),
    .br_taken_i   (br_taken),
    .jump_i       (jump),
    .jr_i         (jr),
    .jr_target_i  (jr_target),
    .link_addr_o  (link_addr),
    .active_o     (active),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          waits;
    int          stalls;
    logic        stall_jump;
    logic        br;
    logic        jmp;
    logic        jrr;
    logic [31:0] tgt;
    logic [31:0] addr;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] addr_q [$];
  logic [31:0] data_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  // Instruction memory contents seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC00010: return 32'h1000FFFF;   // beq, imm -1
      32'hBFC00018: return 32'h0BF00008;   // j 0xBFC00020
      default:      return {a[15:0], a[31:16]};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One instruction: fetch with wait states, EXEC with optional stalls.
  task automatic run_vec(input vec_t v);
    logic [31:0] a, w;
    a = addr_q.pop_front();
    chk("fetch_req", {31'd0, ibus.instr_read}, 32'd1);
    chk("fetch_addr", ibus.instr_address, a);
    chk("fetch_no_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < v.waits; i++) begin
      ibus.instr_waitrequest = 1'b1;
      ibus.instr_readdata    = 32'hDEADBEEF;
      step();
      chk("wait_addr_hold", ibus.instr_address, a);
      chk("wait_read_hold", {31'd0, ibus.instr_read}, 32'd1);
    end
    w = mem_word(a);
    ibus.instr_waitrequest = 1'b0;
    ibus.instr_readdata    = w;
    data_q.push_back(w);
    step();
    ibus.instr_readdata = 32'hDEADBEEF;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_no_read", {31'd0, ibus.instr_read}, 32'd0);
    chk("exec_ir", instr_out, data_q.pop_front());
    chk("exec_link", link_addr, a + 32'd8);
    for (int i = 0; i < v.stalls; i++) begin
      stall = 1'b1;
      jump  = v.stall_jump;
      step();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_ir", instr_out, w);
    end
    stall     = 1'b0;
    jump      = v.jmp;
    br_taken  = v.br;
    jr        = v.jrr;
    jr_target = v.tgt;
    step();
    jump = 1'b0; br_taken = 1'b0; jr = 1'b0; jr_target = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_read", {31'd0, ibus.instr_read}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ir", instr_out, 32'h0);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc", ibus.instr_address, 32'hBFC00000);
    reset = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clk_enable = 1'b1; stall = 1'b0; br_taken = 1'b0;
    jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
    ibus.instr_waitrequest = 1'b0;
    ibus.instr_readdata    = 32'h0;

    //            waits stl sj    br    jmp   jr    tgt            addr
    tbl[0]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC00000};
    tbl[1]  = '{3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC00004};
    tbl[2]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC00008};
    tbl[3]  = '{0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC0000C};
    tbl[4]  = '{0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'hBFC00010};
    tbl[5]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'hBFC00014};
    tbl[6]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC00010};
    tbl[7]  = '{1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC00014};
    tbl[8]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'hBFC00018};
    tbl[9]  = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC0001C};
    tbl[10] = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000,  32'hBFC00020};
    tbl[11] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC00024};

    do_reset();
    for (int i = 0; i < 12; i++) addr_q.push_back(tbl[i].addr);
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Halt after the jr-to-0 delay slot; stays halted.
    for (int i = 0; i < 3; i++) begin
      chk("halt_active", {31'd0, active}, 32'd0);
      chk("halt_read", {31'd0, ibus.instr_read}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end

    // clk_enable low holds the fetch even with memory ready.
    do_reset();
    clk_enable = 1'b0;
    ibus.instr_waitrequest = 1'b0;
    ibus.instr_readdata    = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ce_read_hold", {31'd0, ibus.instr_read}, 32'd1);
      chk("ce_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("ce_ir_hold", instr_out, 32'h0);
      chk("ce_addr_hold", ibus.instr_address, 32'hBFC00000);
    end
    clk_enable = 1'b1;

    // Reset in the middle of a waited fetch abandons the request.
    ibus.instr_waitrequest = 1'b1;
    step();
    chk("midf_read", {31'd0, ibus.instr_read}, 32'd1);
    reset = 1'b1;
    ibus.instr_waitrequest = 1'b0;
    step();
    chk("midf_read_drop", {31'd0, ibus.instr_read}, 32'd0);
    chk("midf_ir", instr_out, 32'h0);
    chk("midf_valid", {31'd0, instr_valid}, 32'd0);

    // Misaligned jr target.
    do_reset();
    addr_q.push_back(32'hBFC00000);
    addr_q.push_back(32'hBFC00004);
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC00102, 32'hBFC00000});
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hBFC00004});
`ifdef ALIGN_CHECK_EN
    chk("align_fault", {31'd0, fault}, 32'd1);
    chk("align_active", {31'd0, active}, 32'd0);
    chk("align_no_read", {31'd0, ibus.instr_read}, 32'd0);
`else
    chk("align_fault", {31'd0, fault}, 32'd0);
    chk("align_read", {31'd0, ibus.instr_read}, 32'd1);
    chk("align_addr", ibus.instr_address, 32'hBFC00100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
